// File: rtl/front_panel_dmux_if.sv
// Signal bundle between the front panel and CPU on one side and the
// display/switch demultiplexer on the other side.
interface front_panel_dmux_if;
  logic        clear;
  logic        extd_addr;
  logic        addr_load;
  logic        dep;
  logic        exam;
  logic        cont;
  logic        dsel_sw;
  logic [0:11] sr;
  logic [0:11] rsr;
  logic        cleard;
  logic        extd_addrd;
  logic        addr_loadd;
  logic        depd;
  logic        examd;
  logic        contd;
  logic [2:0]  dsel;
  logic        sw_active;
  logic [4:0]  state;
  logic [3:11] state1;
  logic [0:11] status;
  logic [0:11] ac;
  logic [0:11] mb;
  logic [0:11] mq;
  logic [0:11] io_bus;
  logic        run_ff;
  logic [0:11] dout;
  logic [0:4]  dsel_led;
  logic        run_led;

  modport master (
    output clear, extd_addr, addr_load, dep, exam, cont, dsel_sw, sr,
    output state, state1, status, ac, mb, mq, io_bus, run_ff,
    input  rsr, cleard, extd_addrd, addr_loadd, depd, examd, contd,
    input  dsel, sw_active, dout, dsel_led, run_led
  );

  modport slave (
    input  clear, extd_addr, addr_load, dep, exam, cont, dsel_sw, sr,
    input  state, state1, status, ac, mb, mq, io_bus, run_ff,
    output rsr, cleard, extd_addrd, addr_loadd, depd, examd, contd,
    output dsel, sw_active, dout, dsel_led, run_led
  );
endinterface

// File: rtl/front_panel_dmux.sv
// Front panel key synchronizer/debouncer plus registered lamp display mux.
// Keys are packed as {clear, extd_addr, addr_load, dep, exam, cont, dsel_sw}.
module front_panel_dmux #(
  parameter int DEBOUNCE = 2
) (
  input  logic               clk,
  input  logic               reset,
  front_panel_dmux_if.slave  bus
);

  localparam int NK = 7;
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int K_DSEL = 0;

  logic [NK-1:0]         key_raw_s;
  logic [NK-1:0]         key_s1_d, key_s1_q;
  logic [NK-1:0]         key_s2_d, key_s2_q;
  logic [NK-1:0]         armed_d, armed_q;
  logic [NK-1:0]         pulse_d, pulse_q;
  logic [NK-1:0][CW-1:0] cnt_d, cnt_q;
  logic [0:11]           sr_s1_d, sr_s1_q;
  logic [0:11]           sr_s2_d, sr_s2_q;
  logic [2:0]            dsel_d, dsel_q;
  logic [0:11]           dout_d, dout_q;
  logic [0:4]            dsel_led_d, dsel_led_q;
  logic                  run_led_d, run_led_q;
  logic                  sw_active_s;

  assign key_raw_s = {bus.clear, bus.extd_addr, bus.addr_load, bus.dep,
                      bus.exam, bus.cont, bus.dsel_sw};

  // dsel_sw only steps the display; it never counts as a held panel key
  assign sw_active_s = |key_s2_q[NK-1:1];

  always_comb begin
    key_s1_d = key_raw_s;
    key_s2_d = key_s1_q;
    sr_s1_d  = bus.sr;
    sr_s2_d  = sr_s1_q;
  end

  // Per-key edge detect: a pulse disarms the key until it has read low
  // for DEBOUNCE consecutive clocks.
  always_comb begin
    armed_d = armed_q;
    pulse_d = '0;
    cnt_d   = cnt_q;
    for (int i = 0; i < NK; i++) begin
      if (armed_q[i]) begin
        cnt_d[i] = '0;
        if (key_s2_q[i]) begin
          armed_d[i] = 1'b0;
          pulse_d[i] = 1'b1;
        end else begin
          armed_d[i] = 1'b1;
        end
      end else if (key_s2_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
        armed_d[i] = 1'b1;
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    dsel_d = dsel_q;
    if (pulse_q[K_DSEL]) begin
      dsel_d = (dsel_q >= 3'd5) ? 3'd0 : dsel_q + 3'd1;
    end else begin
      dsel_d = dsel_q;
    end
  end

  always_comb begin
    dout_d = 12'o0;
    if (sw_active_s) begin
      dout_d = bus.mb;
    end else begin
      case (dsel_q)
        3'd0:    dout_d = {bus.state[4:2], bus.state1[3:11]};
        3'd1:    dout_d = bus.status;
        3'd2:    dout_d = bus.ac;
        3'd3:    dout_d = bus.mb;
        3'd4:    dout_d = bus.mq;
        3'd5:    dout_d = bus.io_bus;
        default: dout_d = 12'o0;
      endcase
    end
  end

  always_comb begin
    dsel_led_d = 5'b00000;
    case (dsel_q)
      3'd1:    dsel_led_d = 5'b10000;
      3'd2:    dsel_led_d = 5'b01000;
      3'd3:    dsel_led_d = 5'b00100;
      3'd4:    dsel_led_d = 5'b00010;
      3'd5:    dsel_led_d = 5'b00001;
      default: dsel_led_d = 5'b00000;
    endcase
    run_led_d = bus.run_ff;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_q   <= '0;
      key_s2_q   <= '0;
      armed_q    <= '1;
      pulse_q    <= '0;
      cnt_q      <= '0;
      sr_s1_q    <= 12'o0;
      sr_s2_q    <= 12'o0;
      dsel_q     <= 3'd0;
      dout_q     <= 12'o0;
      dsel_led_q <= 5'b00000;
      run_led_q  <= 1'b0;
    end else begin
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      armed_q    <= armed_d;
      pulse_q    <= pulse_d;
      cnt_q      <= cnt_d;
      sr_s1_q    <= sr_s1_d;
      sr_s2_q    <= sr_s2_d;
      dsel_q     <= dsel_d;
      dout_q     <= dout_d;
      dsel_led_q <= dsel_led_d;
      run_led_q  <= run_led_d;
    end
  end

  assign bus.rsr        = sr_s2_q;
  assign bus.cleard     = pulse_q[6];
  assign bus.extd_addrd = pulse_q[5];
  assign bus.addr_loadd = pulse_q[4];
  assign bus.depd       = pulse_q[3];
  assign bus.examd      = pulse_q[2];
  assign bus.contd      = pulse_q[1];
  assign bus.dsel       = dsel_q;
  assign bus.sw_active  = sw_active_s;
  assign bus.dout       = dout_q;
  assign bus.dsel_led   = dsel_led_q;
  assign bus.run_led    = run_led_q;

endmodule

// File: tb/tb_front_panel_dmux.sv
// Self-checking bench for front_panel_dmux: reset, key pulses, display mux
// table with a scoreboard queue, synchronizer latency and reset corner cases.
module tb_front_panel_dmux;

  logic clk = 1'b0;
  logic reset;
  front_panel_dmux_if bus();

  front_panel_dmux #(.DEBOUNCE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  dsel;
    logic [0:11] dout;
    logic [0:4]  led;
  } exp_t;

  exp_t tbl [7];
  exp_t sbq [$];

  int checks = 0;
  int failures = 0;

  // Free-running pulse monitors; tests compare snapshots of these totals.
  int clr_hi = 0, clr_rise = 0, exm_hi = 0, dsel_chg = 0;
  logic       clr_prev = 1'b0;
  logic [2:0] dsel_prev = 3'd0;

  always @(negedge clk) begin
    if (bus.cleard === 1'b1) clr_hi = clr_hi + 1;
    if (bus.cleard === 1'b1 && clr_prev !== 1'b1) clr_rise = clr_rise + 1;
    if (bus.examd === 1'b1) exm_hi = exm_hi + 1;
    if (reset === 1'b0 && bus.dsel !== dsel_prev) dsel_chg = dsel_chg + 1;
    clr_prev  = bus.cleard;
    dsel_prev = bus.dsel;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0o expected=%0o", name, act, exp);
    end
  endtask

  task automatic press_dsel();
    bus.dsel_sw = 1'b1;
    tick(1);
    bus.dsel_sw = 1'b0;
    tick(8);
  endtask

  int   c0, c1, e0;
  logic [2:0] d0;
  exp_t got;

  initial begin
    reset = 1'b1;
    {bus.clear, bus.extd_addr, bus.addr_load, bus.dep, bus.exam, bus.cont, bus.dsel_sw} = 7'b0;
    bus.sr = 12'o0; bus.state = 5'b10100; bus.state1 = 9'o777;
    bus.status = 12'o6666; bus.ac = 12'o1111; bus.mb = 12'o3333;
    bus.mq = 12'o2222; bus.io_bus = 12'o5555; bus.run_ff = 1'b0;

    tbl[0] = '{3'd1, 12'o6666, 5'b10000};
    tbl[1] = '{3'd2, 12'o1111, 5'b01000};
    tbl[2] = '{3'd3, 12'o3333, 5'b00100};
    tbl[3] = '{3'd4, 12'o2222, 5'b00010};
    tbl[4] = '{3'd5, 12'o5555, 5'b00001};
    tbl[5] = '{3'd0, 12'o5777, 5'b00000};
    tbl[6] = '{3'd1, 12'o6666, 5'b10000};

    // Reset state
    tick(3);
    chk("rst_rsr", 32'(bus.rsr), 32'o0);
    chk("rst_dout", 32'(bus.dout), 32'o0);
    chk("rst_dsel", 32'(bus.dsel), 32'd0);
    chk("rst_led", 32'(bus.dsel_led), 32'd0);
    chk("rst_run", 32'(bus.run_led), 32'd0);
    chk("rst_pulses", 32'({bus.cleard, bus.extd_addrd, bus.addr_loadd, bus.depd, bus.examd, bus.contd}), 32'd0);
    chk("rst_swact", 32'(bus.sw_active), 32'd0);
    reset = 1'b0;
    tick(4);

    // Dsel 0 state word with idle keys
    chk("state_word", 32'(bus.dout), 32'o5777);
    chk("state_led", 32'(bus.dsel_led), 32'd0);

    // Clear held 5 clocks: pulse pattern and sw_active cycle by cycle
    c0 = clr_hi; c1 = clr_rise;
    bus.clear = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("clr_swact", 32'(bus.sw_active), (i >= 1) ? 32'd1 : 32'd0);
      chk("clr_pulse", 32'(bus.cleard), (i == 2) ? 32'd1 : 32'd0);
      if (i == 3) chk("clr_dout_mb", 32'(bus.dout), 32'o3333);
    end
    bus.clear = 1'b0;
    tick(8);
    chk("clr_hi_cycles", 32'(clr_hi - c0), 32'd1);
    chk("clr_rises", 32'(clr_rise - c1), 32'd1);
    chk("clr_swact_off", 32'(bus.sw_active), 32'd0);

    // Exam 2 high, 3 low, 2 high: two pulses; dout forced to mb while held
    e0 = exm_hi;
    bus.exam = 1'b1; tick(2);
    bus.exam = 1'b0; tick(1);
    chk("exam_dout_mb", 32'(bus.dout), 32'o3333);
    tick(2);
    bus.exam = 1'b1; tick(2);
    bus.exam = 1'b0; tick(8);
    chk("exam_pulses", 32'(exm_hi - e0), 32'd2);

    // Display table: each dsel press pushes the expected lamps, popped after output
    for (int i = 0; i < 7; i++) begin
      press_dsel();
      sbq.push_back(tbl[i]);
      tick(1);
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        got = sbq.pop_front();
        chk($sformatf("tbl%0d_dsel", i), 32'(bus.dsel), 32'(got.dsel));
        chk($sformatf("tbl%0d_dout", i), 32'(bus.dout), 32'(got.dout));
        chk($sformatf("tbl%0d_led", i), 32'(bus.dsel_led), 32'(got.led));
      end
    end

    // sr synchronizer latency and run lamp
    bus.sr = 12'o2525; bus.run_ff = 1'b1;
    tick(1);
    chk("rsr_lat1", 32'(bus.rsr), 32'o0);
    chk("run_led", 32'(bus.run_led), 32'd1);
    tick(1);
    chk("rsr_lat2", 32'(bus.rsr), 32'o2525);

    // dsel_sw held 20 clocks advances exactly once
    d0 = bus.dsel; c0 = dsel_chg;
    bus.dsel_sw = 1'b1; tick(20);
    bus.dsel_sw = 1'b0; tick(8);
    chk("hold_dsel_chg", 32'(dsel_chg - c0), 32'd1);
    chk("hold_dsel_val", 32'(bus.dsel), (d0 == 3'd5) ? 32'd0 : 32'(d0 + 3'd1));

    // Reset mid-press discards the pending pulse; key still high at release pulses once
    c0 = clr_hi;
    bus.clear = 1'b1; tick(2);
    reset = 1'b1; tick(1);
    chk("midrst_dsel", 32'(bus.dsel), 32'd0);
    chk("midrst_pulse", 32'(clr_hi - c0), 32'd0);
    reset = 1'b0;
    c0 = clr_hi;
    tick(2);
    chk("release_no_early", 32'(bus.cleard), 32'd0);
    tick(1);
    chk("release_pulse", 32'(bus.cleard), 32'd1);
    tick(6);
    chk("release_once", 32'(clr_hi - c0), 32'd1);
    bus.clear = 1'b0;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
